// File: rtl/input_conditioner.sv
// Per-bit synchroniser, debouncer and press/release pulse generator for raw pad inputs.
// Optional auto-repeat on held presses is enabled by defining INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rep_fire;
  logic [WIDTH-1:0] press_d;
  logic [WIDTH-1:0] release_d;

  // The synchroniser ignores ena so the debouncer always sees a fresh sample when re-enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = ena && (s[i] != level_o[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  assign press_d   = (accept & s) | rep_fire;
  assign release_d = accept & ~s;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_o   <= '0;
      press_o   <= '0;
      release_o <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      press_o   <= press_d;
      release_o <= release_d;
      if (ena) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (s[i] == level_o[i]) begin
            cnt_q[i] <= '0;
          end else if (accept[i]) begin
            level_o[i] <= s[i];
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end
      end
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]    rcnt_q [WIDTH];
  logic [WIDTH-1:0] rep_phase_q;  // 0: waiting out the initial delay, 1: periodic repeats

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rep_fire[i] = ena && level_o[i] && !accept[i] &&
                    (rep_phase_q[i] ? (rcnt_q[i] == PERIOD_LAST) : (rcnt_q[i] == DELAY_LAST));
    end
  end

  // Counter restarts on every fire, so it is bounded by RMAX-1 and cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_phase_q <= '0;
      for (int i = 0; i < WIDTH; i++) rcnt_q[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!level_o[i] || accept[i]) begin
          rcnt_q[i]      <= '0;
          rep_phase_q[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rcnt_q[i]      <= '0;
          rep_phase_q[i] <= 1'b1;
        end else begin
          rcnt_q[i] <= rcnt_q[i] + RW'(1);
        end
      end
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign rep_fire = '0;
`endif

endmodule
